// File: rtl/sump_cmd_decoder.sv
// Assembles SUMP host bytes into short/long commands and issues one-cycle config strobes.
// Optional inter-byte timeout for long commands is built only when CMD_TIMEOUT_EN is defined.
module sump_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TO_W           = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd_opcode,
  output logic [31:0] cmd_data,
  output logic        flags_wr,
  output logic        arm,
  output logic        id_req,
  output logic        sw_reset,
  output logic        busy,
  output logic        err_timeout
);

  typedef enum logic {IDLE, DATA} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] sh_q, sh_d;
  logic [7:0]  op_q, op_d;

  logic        fire;
  logic [7:0]  fire_op;
  logic [31:0] fire_dat;
  logic        to_hit;
  logic        to_fire;

`ifdef CMD_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_SAT  = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_q;

  // Cleared by every byte; counts only while a long command is open.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_q <= '0;
    end else if (rx_valid) begin
      to_q <= '0;
    end else if (state_q == DATA && to_q != TO_SAT) begin
      to_q <= to_q + 1'b1;
    end
  end

  assign to_hit = (state_q == DATA) && (to_q == TO_LAST);
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES != 0) ^ (TO_W != 0);
  assign to_hit     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      sh_q    <= 32'd0;
      op_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    op_d     = op_q;
    fire     = 1'b0;
    fire_op  = op_q;
    fire_dat = 32'd0;
    to_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (!rx_data[7]) begin
            fire    = 1'b1;
            fire_op = rx_data;
          end else begin
            op_d    = rx_data;
            cnt_d   = 2'd0;
            sh_d    = 32'd0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        // A byte arriving in the timeout cycle takes priority over the abort.
        if (rx_valid) begin
          sh_d  = {rx_data, sh_q[31:8]};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            fire     = 1'b1;
            fire_op  = op_q;
            fire_dat = {rx_data, sh_q[31:8]};
            state_d  = IDLE;
          end
        end else if (to_hit) begin
          to_fire = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid   <= 1'b0;
      cmd_opcode  <= 8'd0;
      cmd_data    <= 32'd0;
      flags_wr    <= 1'b0;
      arm         <= 1'b0;
      id_req      <= 1'b0;
      sw_reset    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      cmd_valid   <= fire;
      flags_wr    <= fire && (fire_op == 8'h82);
      arm         <= fire && (fire_op == 8'h01);
      id_req      <= fire && (fire_op == 8'h02);
      sw_reset    <= fire && (fire_op == 8'h00);
      err_timeout <= to_fire;
      if (fire) begin
        cmd_opcode <= fire_op;
        cmd_data   <= fire_dat;
      end
    end
  end

  assign busy = (state_q == DATA);

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Directed bench for sump_cmd_decoder: byte table plus hand-written reset/timeout sequences.
module tb_sump_cmd_decoder;

  logic        clk;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        cmd_valid;
  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_data;
  logic        flags_wr;
  logic        arm;
  logic        id_req;
  logic        sw_reset;
  logic        busy;
  logic        err_timeout;

  sump_cmd_decoder #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .cmd_valid(cmd_valid), .cmd_opcode(cmd_opcode), .cmd_data(cmd_data),
    .flags_wr(flags_wr), .arm(arm), .id_req(id_req), .sw_reset(sw_reset),
    .busy(busy), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b;
    logic        v;
    logic [7:0]  op;
    logic [31:0] dat;
    logic        bsy;
    logic [3:0]  strb;  // {flags_wr, arm, id_req, sw_reset}
  } vec_t;

  localparam int NV = 26;
  vec_t vecs[NV];
  int n_chk = 0;
  int n_pass = 0;

  function automatic vec_t mk(logic [7:0] b, logic v, logic [7:0] op, logic [31:0] dat,
                              logic bsy, logic [3:0] strb);
    vec_t r;
    r.b = b; r.v = v; r.op = op; r.dat = dat; r.bsy = bsy; r.strb = strb;
    return r;
  endfunction

  function automatic logic [46:0] pack_exp(logic v, logic [7:0] op, logic [31:0] dat,
                                           logic bsy, logic [3:0] strb, logic err);
    return {v, op, dat, bsy, strb, err};
  endfunction

  function automatic logic [46:0] pack_act();
    return {cmd_valid, cmd_opcode, cmd_data, busy, flags_wr, arm, id_req, sw_reset, err_timeout};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int err_cnt;
    int err_at;
    int vld_cnt;

    vecs[0]  = mk(8'h01, 1, 8'h01, 32'h0, 0, 4'b0100);
    vecs[1]  = mk(8'h82, 0, 8'h01, 32'h0, 1, 4'b0000);
    vecs[2]  = mk(8'h04, 0, 8'h01, 32'h0, 1, 4'b0000);
    vecs[3]  = mk(8'h01, 0, 8'h01, 32'h0, 1, 4'b0000);
    vecs[4]  = mk(8'h00, 0, 8'h01, 32'h0, 1, 4'b0000);
    vecs[5]  = mk(8'h00, 1, 8'h82, 32'h0000_0104, 0, 4'b1000);
    vecs[6]  = mk(8'h81, 0, 8'h82, 32'h0000_0104, 1, 4'b0000);
    vecs[7]  = mk(8'h00, 0, 8'h82, 32'h0000_0104, 1, 4'b0000);
    vecs[8]  = mk(8'h00, 0, 8'h82, 32'h0000_0104, 1, 4'b0000);
    vecs[9]  = mk(8'h00, 0, 8'h82, 32'h0000_0104, 1, 4'b0000);
    vecs[10] = mk(8'h00, 1, 8'h81, 32'h0, 0, 4'b0000);
    vecs[11] = mk(8'h00, 1, 8'h00, 32'h0, 0, 4'b0001);
    vecs[12] = mk(8'h05, 1, 8'h05, 32'h0, 0, 4'b0000);
    vecs[13] = mk(8'h02, 1, 8'h02, 32'h0, 0, 4'b0010);
    vecs[14] = mk(8'h00, 1, 8'h00, 32'h0, 0, 4'b0001);
    vecs[15] = mk(8'h85, 0, 8'h00, 32'h0, 1, 4'b0000);
    vecs[16] = mk(8'h11, 0, 8'h00, 32'h0, 1, 4'b0000);
    vecs[17] = mk(8'h22, 0, 8'h00, 32'h0, 1, 4'b0000);
    vecs[18] = mk(8'h33, 0, 8'h00, 32'h0, 1, 4'b0000);
    vecs[19] = mk(8'h44, 1, 8'h85, 32'h4433_2211, 0, 4'b0000);
    vecs[20] = mk(8'h80, 0, 8'h85, 32'h4433_2211, 1, 4'b0000);
    vecs[21] = mk(8'h00, 0, 8'h85, 32'h4433_2211, 1, 4'b0000);
    vecs[22] = mk(8'h00, 0, 8'h85, 32'h4433_2211, 1, 4'b0000);
    vecs[23] = mk(8'h00, 0, 8'h85, 32'h4433_2211, 1, 4'b0000);
    vecs[24] = mk(8'h00, 1, 8'h80, 32'h0, 0, 4'b0000);
    vecs[25] = mk(8'h00, 1, 8'h00, 32'h0, 0, 4'b0001);

    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    idle(2);
    check("reset_state", 64'(pack_act()), 64'(pack_exp(0, 8'h00, 32'h0, 0, 4'b0000, 0)));
    rst = 1'b0;
    idle(1);

    for (int i = 0; i < NV; i++) begin
      send(vecs[i].b);
      check($sformatf("vec%0d", i), 64'(pack_act()),
            64'(pack_exp(vecs[i].v, vecs[i].op, vecs[i].dat, vecs[i].bsy, vecs[i].strb, 0)));
    end

    // Strobes fall after one cycle while opcode/data hold.
    idle(1);
    check("strobe_one_cycle", 64'(pack_act()), 64'(pack_exp(0, 8'h00, 32'h0, 0, 4'b0000, 0)));

    // Reset in the middle of a long command discards it.
    send(8'h80);
    send(8'h11);
    send(8'h22);
    check("busy_before_rst", 64'(busy), 64'(1'b1));
    rst = 1'b1;
    #1;
    check("rst_mid_cmd", 64'(pack_act()), 64'(pack_exp(0, 8'h00, 32'h0, 0, 4'b0000, 0)));
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    check("after_rst_idle", 64'(pack_act()), 64'(pack_exp(0, 8'h00, 32'h0, 0, 4'b0000, 0)));
    send(8'h02);
    check("id_after_rst", 64'(pack_act()), 64'(pack_exp(1, 8'h02, 32'h0, 0, 4'b0010, 0)));
    idle(1);

`ifdef CMD_TIMEOUT_EN
    // Abort fires 16 clocks after the last byte with no command strobe.
    send(8'h80);
    send(8'hAA);
    err_cnt = 0; err_at = -1; vld_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (err_timeout) begin
        err_cnt++;
        if (err_at < 0) err_at = i;
      end
      if (cmd_valid) vld_cnt++;
    end
    check("timeout_at", 64'(err_at), 64'(16));
    check("timeout_pulses", 64'(err_cnt), 64'(1));
    check("timeout_no_cmd", 64'(vld_cnt), 64'(0));
    check("timeout_busy", 64'(busy), 64'(1'b0));
    send(8'h02);
    check("id_after_timeout", 64'(pack_act()), 64'(pack_exp(1, 8'h02, 32'h0, 0, 4'b0010, 0)));

    // Byte landing in the timeout cycle wins.
    send(8'h80);
    send(8'hAA);
    err_cnt = 0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk);
      #1;
      if (err_timeout) err_cnt++;
    end
    send(8'hBB);
    if (err_timeout) err_cnt++;
    check("byte_wins_no_err", 64'(err_cnt), 64'(0));
    check("byte_wins_busy", 64'(busy), 64'(1'b1));
    send(8'hCC);
    send(8'hDD);
    check("byte_wins_cmd", 64'(pack_act()),
          64'(pack_exp(1, 8'h80, 32'hDDCC_BBAA, 0, 4'b0000, 0)));
`else
    // Without the timeout, a long command waits indefinitely.
    send(8'h80);
    send(8'h11);
    err_cnt = 0; vld_cnt = 0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      #1;
      if (err_timeout) err_cnt++;
      if (!busy) vld_cnt++;
    end
    check("no_timeout_err", 64'(err_cnt), 64'(0));
    check("no_timeout_busy_drop", 64'(vld_cnt), 64'(0));
    send(8'h22);
    send(8'h33);
    send(8'h44);
    check("late_long_cmd", 64'(pack_act()),
          64'(pack_exp(1, 8'h80, 32'h4433_2211, 0, 4'b0000, 0)));
`endif

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
